throw_ctrl: RTL and testbench

THROW_CTRL -- requirements
Module: throw_ctrl

---
 rtl/throw_pkg.sv | 44 ++++
 rtl/throw_ctrl_frame_tick_gen.sv | 33 +++
 rtl/throw_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_throw_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/throw_pkg.sv
// throw_pkg -- shared types and constants for the projectile ("throw")
// sprite controller and its helpers.
//   state_e   : controller FSM states
//   PARK_POS  : sprite origin used while the projectile is not on screen
//   ID_FLY / ID_EXPLODE : sprite ids driven on ctrl[1:0]
//   vy_sat_inc : gravity step on the 6-bit signed vertical velocity
//   pos_add    : 12-bit signed position update
//   off_limit  : off-screen test on an updated 12-bit coordinate
package throw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_FLY     = 2'd2,
    ST_EXPLODE = 2'd3
  } state_e;

  localparam logic [10:0] PARK_POS   = 11'h7FF;
  localparam logic [1:0]  ID_FLY     = 2'd0;
  localparam logic [1:0]  ID_EXPLODE = 2'd3;

  // Gravity adds +1 but never pushes the velocity past +15.
  function automatic logic [5:0] vy_sat_inc(input logic [5:0] v);
    if ($signed(v) < 6'sd15) begin
      return v + 6'd1;
    end
    return v;
  endfunction

  // Unsigned 11-bit position plus a sign-extended 12-bit delta; the result
  // is interpreted as 12-bit signed so a move above/left of 0 stays negative.
  function automatic logic [11:0] pos_add(input logic [10:0] p,
                                          input logic [11:0] d);
    return {1'b0, p} + d;
  endfunction

  // Negative results count as off-screen (never wrapped); otherwise compare
  // against the visible limit.
  function automatic logic off_limit(input logic [11:0] n,
                                     input logic [11:0] lim);
    return n[11] || (n >= lim);
  endfunction

endpackage

// File: rtl/throw_ctrl_frame_tick_gen.sv
// frame_tick_gen -- one-cycle pulse at the start of each video frame.
// Fires when the previous scan x was 0 and the current scan position is
// (x=1, y=0). Kept standalone so several sprite controllers can share it.
//   clk    : system clock
//   reset  : synchronous active-high reset
//   x_i    : current scan x
//   y_i    : current scan y
//   tick_o : frame tick (combinational from x_i/y_i and registered prev x)
module frame_tick_gen
  import throw_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] x_i,
  input  logic [10:0] y_i,
  output logic        tick_o
);

  logic [10:0] prev_x_q;

  // Reset to a non-zero value so the first cycle after reset can never look
  // like the x=0 -> x=1 transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_x_q <= PARK_POS;
    end else begin
      prev_x_q <= x_i;
    end
  end

  assign tick_o = (prev_x_q == 11'd0) && (x_i == 11'd1) && (y_i == 11'd0);

endmodule

// File: rtl/throw_ctrl.sv
// throw_ctrl -- projectile sprite controller.
// A launch request arms the projectile; on the next frame tick it appears at
// the spawn point and then moves every frame under constant horizontal
// velocity and gravity-driven vertical velocity. It leaves the screen (done)
// or, when hit, freezes and plays an explosion for EXP_FRAMES frames (done).
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   x, y                 : scan coordinates from the sync generator
//   launch               : one-cycle launch request (honoured only in IDLE)
//   launch_x, launch_y   : spawn position
//   vx                   : signed 4-bit horizontal velocity, pixels/frame
//   vy0                  : signed 6-bit initial vertical velocity (neg = up)
//   color_sel            : body colour, reported on ctrl[4:3]
//   hit                  : one-cycle collision indication
//   x0, y0               : sprite origin (7FF when parked)
//   ctrl                 : {colour, auto-animate, sprite id}
//   busy                 : high whenever not IDLE
//   done                 : one-cycle pulse on return to IDLE
// All outputs are registered.
module throw_ctrl
  import throw_pkg::*;
#(
  parameter int H_MAX      = 640,
  parameter int V_MAX      = 480,
  parameter int EXP_FRAMES = 16,
  parameter int GRAV_DIV   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic        launch,
  input  logic [10:0] launch_x,
  input  logic [10:0] launch_y,
  input  logic [3:0]  vx,
  input  logic [5:0]  vy0,
  input  logic [1:0]  color_sel,
  input  logic        hit,
  output logic [10:0] x0,
  output logic [10:0] y0,
  output logic [4:0]  ctrl,
  output logic        busy,
  output logic        done
);

  localparam int GW = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
  localparam int EW = (EXP_FRAMES > 1) ? $clog2(EXP_FRAMES) : 1;
  localparam logic [GW-1:0] GRAV_LAST = GW'(GRAV_DIV - 1);
  localparam logic [EW-1:0] EXP_LAST  = EW'(EXP_FRAMES - 1);
  localparam logic [11:0]   H_LIM     = 12'(H_MAX);
  localparam logic [11:0]   V_LIM     = 12'(V_MAX);

  state_e         state_q, state_d;
  logic [10:0]    cap_x_q, cap_x_d;
  logic [10:0]    cap_y_q, cap_y_d;
  logic [3:0]     vx_q, vx_d;
  logic [5:0]     vy_q, vy_d;
  logic [1:0]     col_q, col_d;
  logic [GW-1:0]  grav_cnt_q, grav_cnt_d;
  logic [EW-1:0]  exp_cnt_q, exp_cnt_d;
  logic [10:0]    x0_q, x0_d;
  logic [10:0]    y0_q, y0_d;
  logic [4:0]     ctrl_q, ctrl_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           frame_tick;
  logic [11:0]    nx, ny;
  logic           x_off, y_off;

  frame_tick_gen u_tick (
    .clk    (clk),
    .reset  (reset),
    .x_i    (x),
    .y_i    (y),
    .tick_o (frame_tick)
  );

  // Candidate next position for this frame, evaluated against the screen.
  assign nx    = pos_add(x0_q, {{8{vx_q[3]}}, vx_q});
  assign ny    = pos_add(y0_q, {{6{vy_q[5]}}, vy_q});
  assign x_off = off_limit(nx, H_LIM);
  assign y_off = off_limit(ny, V_LIM);

  always_comb begin
    state_d    = state_q;
    cap_x_d    = cap_x_q;
    cap_y_d    = cap_y_q;
    vx_d       = vx_q;
    vy_d       = vy_q;
    col_d      = col_q;
    grav_cnt_d = grav_cnt_q;
    exp_cnt_d  = exp_cnt_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    ctrl_d     = ctrl_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // The cycle that shows done must not restart a flight.
        if (launch && !done_q) begin
          state_d    = ST_ARMED;
          cap_x_d    = launch_x;
          cap_y_d    = launch_y;
          vx_d       = vx;
          vy_d       = vy0;
          col_d      = color_sel;
          grav_cnt_d = '0;
          exp_cnt_d  = '0;
          x0_d       = PARK_POS;
          y0_d       = PARK_POS;
          ctrl_d     = {color_sel, 3'b000};
          busy_d     = 1'b1;
        end
      end

      ST_ARMED: begin
        if (frame_tick) begin
          state_d    = ST_FLY;
          x0_d       = cap_x_q;
          y0_d       = cap_y_q;
          grav_cnt_d = '0;
          ctrl_d     = {col_q, 1'b1, ID_FLY};
        end
      end

      ST_FLY: begin
        // A hit takes priority over any movement or off-screen exit that
        // the same cycle's frame tick would have caused.
        if (hit) begin
          state_d   = ST_EXPLODE;
          exp_cnt_d = '0;
          ctrl_d    = {col_q, 1'b0, ID_EXPLODE};
        end else if (frame_tick) begin
          if (x_off || y_off) begin
            state_d = ST_IDLE;
            x0_d    = PARK_POS;
            y0_d    = PARK_POS;
            ctrl_d  = {col_q, 3'b000};
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            x0_d = nx[10:0];
            y0_d = ny[10:0];
            // Gravity is applied after the move, once every GRAV_DIV frames.
            if (grav_cnt_q == GRAV_LAST) begin
              grav_cnt_d = '0;
              vy_d       = vy_sat_inc(vy_q);
            end else begin
              grav_cnt_d = grav_cnt_q + GW'(1);
            end
          end
        end
      end

      ST_EXPLODE: begin
        if (frame_tick) begin
          if (exp_cnt_q == EXP_LAST) begin
            state_d = ST_IDLE;
            x0_d    = PARK_POS;
            y0_d    = PARK_POS;
            ctrl_d  = {col_q, 3'b000};
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            exp_cnt_d = exp_cnt_q + EW'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cap_x_q    <= '0;
      cap_y_q    <= '0;
      vx_q       <= '0;
      vy_q       <= '0;
      col_q      <= '0;
      grav_cnt_q <= '0;
      exp_cnt_q  <= '0;
      x0_q       <= PARK_POS;
      y0_q       <= PARK_POS;
      ctrl_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cap_x_q    <= cap_x_d;
      cap_y_q    <= cap_y_d;
      vx_q       <= vx_d;
      vy_q       <= vy_d;
      col_q      <= col_d;
      grav_cnt_q <= grav_cnt_d;
      exp_cnt_q  <= exp_cnt_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      ctrl_q     <= ctrl_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign x0   = x0_q;
  assign y0   = y0_q;
  assign ctrl = ctrl_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_throw_ctrl.sv
module tb_throw_ctrl;

  localparam int HM    = 640;
  localparam int VM    = 480;
  localparam int EXPF  = 16;
  localparam int GDIV  = 2;
  localparam int PARK  = 2047;
  localparam int NEUT  = 100;

  logic        clk;
  logic        reset;
  logic [10:0] sx, sy;
  logic        launch;
  logic [10:0] lx, ly;
  logic [3:0]  lvx;
  logic [5:0]  lvy0;
  logic [1:0]  col_sel;
  logic        hit;
  logic [10:0] x0, y0;
  logic [4:0]  ctrl;
  logic        busy, done;

  int checks;
  int failures;

  throw_ctrl #(
    .H_MAX(HM), .V_MAX(VM), .EXP_FRAMES(EXPF), .GRAV_DIV(GDIV)
  ) dut (
    .clk(clk), .reset(reset), .x(sx), .y(sy),
    .launch(launch), .launch_x(lx), .launch_y(ly),
    .vx(lvx), .vy0(lvy0), .color_sel(col_sel), .hit(hit),
    .x0(x0), .y0(y0), .ctrl(ctrl), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  // Reference: vertical velocity used for the i-th in-flight move.
  function automatic int vy_at(input int v0, input int i);
    int v;
    v = v0 + (i - 1) / GDIV;
    if (v > 15) v = 15;
    return v;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_out(input string tag, input int ex0, input int ey0,
                           input int ectrl, input int ebusy, input int edone);
    chk($sformatf("%s.x0", tag),   int'(x0),   ex0);
    chk($sformatf("%s.y0", tag),   int'(y0),   ey0);
    chk($sformatf("%s.ctrl", tag), int'(ctrl), ectrl);
    chk($sformatf("%s.busy", tag), int'(busy), ebusy);
    chk($sformatf("%s.done", tag), int'(done), edone);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Two-cycle scan fragment producing exactly one frame tick; optional hit
  // on the tick cycle itself.
  task automatic tick(input bit with_hit);
    sx = 11'd0; sy = 11'd0;
    cyc();
    sx = 11'd1; sy = 11'd0; hit = with_hit;
    cyc();
    hit = 1'b0; sx = 11'(NEUT); sy = 11'(NEUT);
  endtask

  task automatic pulse_launch(input int px, input int py, input int pvx,
                              input int pvy, input int pcol);
    lx = 11'(px); ly = 11'(py); lvx = 4'(pvx); lvy0 = 6'(pvy);
    col_sel = 2'(pcol); launch = 1'b1;
    cyc();
    launch = 1'b0;
  endtask

  task automatic explode_phase(input int ex, input int ey, input int col);
    for (int k = 1; k <= EXPF; k++) begin
      tick(1'b0);
      if (k < EXPF) check_out($sformatf("explode%0d", k), ex, ey, col*8+3, 1, 0);
      else          check_out("exp_done", PARK, PARK, col*8, 0, 1);
    end
    cyc();
    chk("exp_done_drop", int'(done), 0);
  endtask

  task automatic run_flight(input int px, input int py, input int pvx,
                            input int pvy, input int col, input int hit_at,
                            input bit coinc);
    int ex, ey, nx, ny, j;
    bit ended;
    ended = 1'b0;
    $display("flight launch=(%0d,%0d) vx=%0d vy0=%0d col=%0d hit_at=%0d coinc=%0d",
             px, py, pvx, pvy, col, hit_at, coinc);
    pulse_launch(px, py, pvx, pvy, col);
    check_out("armed", PARK, PARK, col*8, 1, 0);
    tick(1'b0);
    ex = px; ey = py;
    check_out("spawn", ex, ey, col*8+4, 1, 0);
    j = 1;
    while (!ended && j <= 300) begin
      if (hit_at == j) begin
        if (coinc) tick(1'b1);
        else begin
          hit = 1'b1; cyc(); hit = 1'b0;
        end
        check_out("hit", ex, ey, col*8+3, 1, 0);
        explode_phase(ex, ey, col);
        ended = 1'b1;
      end else begin
        tick(1'b0);
        nx = ex + pvx;
        ny = ey + vy_at(pvy, j);
        if (nx < 0 || nx >= HM || ny < 0 || ny >= VM) begin
          check_out("offscreen", PARK, PARK, col*8, 0, 1);
          cyc();
          chk("off_done_drop", int'(done), 0);
          ended = 1'b1;
        end else begin
          ex = nx; ey = ny;
          check_out($sformatf("fly%0d", j), ex, ey, col*8+4, 1, 0);
        end
      end
      j++;
    end
    chk("flight_bound", int'(ended), 1);
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; launch = 1'b0; hit = 1'b0;
    sx = 11'(NEUT); sy = 11'(NEUT);
    lx = '0; ly = '0; lvx = '0; lvy0 = '0; col_sel = '0;
    cyc(); cyc();
    check_out("reset", PARK, PARK, 0, 0, 0);
    reset = 1'b0;
    cyc();

    // Ticks and hits do nothing while idle.
    tick(1'b1);
    check_out("idle_hit", PARK, PARK, 0, 0, 0);

    // Basic trajectory with gravity, then hit between ticks and explosion.
    pulse_launch(100, 200, 3, 0, 1);
    check_out("v35_armed", PARK, PARK, 8, 1, 0);
    tick(1'b0); check_out("v35_f1", 100, 200, 12, 1, 0);
    tick(1'b0); check_out("v35_f2", 103, 200, 12, 1, 0);
    tick(1'b0); check_out("v35_f3", 106, 200, 12, 1, 0);
    tick(1'b0); check_out("v35_f4", 109, 201, 12, 1, 0);
    hit = 1'b1; cyc(); hit = 1'b0;
    check_out("v37_hit", 109, 201, 11, 1, 0);
    explode_phase(109, 201, 1);

    // Exit past the right edge.
    run_flight(630, 10, 7, 0, 3, 0, 1'b0);
    // Hit on the same tick as the off-screen exit: explosion wins.
    run_flight(630, 10, 7, 0, 0, 2, 1'b1);

    // Launch/hit ignored while armed, launch ignored in flight, reset aborts.
    pulse_launch(200, 100, 2, 0, 1);
    pulse_launch(50, 50, -3, -5, 2);
    check_out("armed_relaunch", PARK, PARK, 8, 1, 0);
    hit = 1'b1; cyc(); hit = 1'b0;
    check_out("armed_hit", PARK, PARK, 8, 1, 0);
    tick(1'b0); check_out("v39_spawn", 200, 100, 12, 1, 0);
    pulse_launch(10, 10, -8, -8, 3);
    check_out("fly_relaunch", 200, 100, 12, 1, 0);
    tick(1'b0); check_out("v39_f2", 202, 100, 12, 1, 0);
    reset = 1'b1; cyc();
    check_out("reset_fly", PARK, PARK, 0, 0, 0);
    reset = 1'b0; cyc();
    chk("reset_fly_nodone", int'(done), 0);

    // Reset in the middle of an explosion.
    pulse_launch(300, 300, 1, 0, 2);
    tick(1'b0);
    hit = 1'b1; cyc(); hit = 1'b0;
    tick(1'b0); tick(1'b0);
    check_out("exp_mid", 300, 300, 19, 1, 0);
    reset = 1'b1; cyc();
    check_out("reset_exp", PARK, PARK, 0, 0, 0);
    reset = 1'b0; cyc();
    chk("reset_exp_nodone", int'(done), 0);

    // Upward exit past the top edge must not wrap; launch on the done cycle.
    pulse_launch(300, 5, 0, -20, 1);
    tick(1'b0); check_out("v40_spawn", 300, 5, 12, 1, 0);
    tick(1'b0); check_out("v40_off", PARK, PARK, 8, 0, 1);
    pulse_launch(40, 40, 1, 1, 2);
    check_out("launch_on_done", PARK, PARK, 8, 0, 0);
    cyc();
    chk("launch_on_done_busy", int'(busy), 0);

    // Later launch after all of the above works normally.
    run_flight(320, 240, -2, -4, 2, 0, 1'b0);

    // Randomised flights against the reference model.
    for (int n = 0; n < 25; n++) begin
      run_flight(int'($urandom_range(0, HM-1)), int'($urandom_range(0, VM-1)),
                 int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 47)) - 32,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
                 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
